// File: rtl/i2c_passthru_mstr_arb_if.sv
// Bus bundle between the per-channel idle/stuck blocks, the master arbiter
// and the bit rx/tx datapath mux.
// master: the side that drives channel status and observes the grant.
// slave:  the arbiter itself.
interface i2c_passthru_mstr_arb_if #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH_CH = 2
);
    logic                i_f_ref;
    logic [NUM_CH-1:0]   i_idle;
    logic [NUM_CH-1:0]   i_stuck;
    logic [NUM_CH-1:0]   i_mask;
    logic                i_violation;
    logic [NUM_CH-1:0]   o_ismst;
    logic [WIDTH_CH-1:0] o_mst_idx;
    logic                o_mst_valid;
    logic                o_disconnect;
    logic                o_grant;
    logic                o_collision;

    modport master (
        output i_f_ref, i_idle, i_stuck, i_mask, i_violation,
        input  o_ismst, o_mst_idx, o_mst_valid, o_disconnect, o_grant, o_collision
    );

    modport slave (
        input  i_f_ref, i_idle, i_stuck, i_mask, i_violation,
        output o_ismst, o_mst_idx, o_mst_valid, o_disconnect, o_grant, o_collision
    );
endinterface

// File: rtl/i2c_passthru_mstr_arb.sv
// N-channel I2C/SMBus passthrough master arbiter.
// The first enabled channel to leave idle becomes master; simultaneous starts
// are resolved round-robin from the last grant or by lowest index. A bit
// violation, an enabled stuck bus or the master being disabled forces a
// disconnect. Both normal release and disconnect wait for a t_buf quiet
// period (counted in f_ref rising edges) before a new grant can be made.
module i2c_passthru_mstr_arb #(
    parameter int NUM_CH            = 4,
    parameter int WIDTH_CH          = 2,
    parameter int RR_EN             = 1,
    parameter int F_REF_T_BUF       = 38,
    parameter int WIDTH_F_REF_T_BUF = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    i2c_passthru_mstr_arb_if.slave   bus
);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        OWN  = 2'd1,
        BUF  = 2'd2,
        DISC = 2'd3
    } state_e;

    localparam logic [WIDTH_F_REF_T_BUF-1:0] CNT_MAX = WIDTH_F_REF_T_BUF'(F_REF_T_BUF);
    localparam logic [WIDTH_F_REF_T_BUF-1:0] CNT_ONE = WIDTH_F_REF_T_BUF'(1);
    localparam logic [WIDTH_CH-1:0]          IDX_RST = WIDTH_CH'(NUM_CH - 1);

    state_e                         state_q, state_d;
    logic                           f_ref_q;
    logic [WIDTH_F_REF_T_BUF-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]              ismst_q, ismst_d;
    logic [WIDTH_CH-1:0]            idx_q, idx_d;
    logic                           valid_q, valid_d;
    logic                           grant_q, grant_d;
    logic                           coll_q, coll_d;
    logic                           disc_q, disc_d;

    logic                           tick;
    logic [NUM_CH-1:0]              req;
    logic                           stuck_any;
    logic                           quiet;
    logic                           multi_req;
    logic [WIDTH_CH-1:0]            win_idx;

    // Winner among the requesting channels. The last grant is held in the
    // index register, so the round-robin search starts one past it.
    function automatic logic [WIDTH_CH-1:0] pick_winner(
        input logic [NUM_CH-1:0]   r,
        input logic [WIDTH_CH-1:0] last
    );
        logic [WIDTH_CH-1:0] win;
        logic [WIDTH_CH-1:0] ci;
        logic                hit;
        int                  c;
        win = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_EN != 0) begin
                c = (int'(last) + k + 1) % NUM_CH;
            end else begin
                c = k;
            end
            ci = c[WIDTH_CH-1:0];
            if (!hit && r[ci]) begin
                hit = 1'b1;
                win = ci;
            end
        end
        return win;
    endfunction

    assign tick      = bus.i_f_ref & ~f_ref_q;
    assign req       = ~bus.i_idle & bus.i_mask & ~bus.i_stuck;
    assign stuck_any = |(bus.i_stuck & bus.i_mask);
    assign quiet     = (&(bus.i_idle | ~bus.i_mask)) & ~stuck_any;
    assign multi_req = |(req & (req - NUM_CH'(1)));
    assign win_idx   = pick_winner(req, idx_q);

    // State, quiet counter, f_ref edge detector and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ARM;
            f_ref_q <= 1'b0;
            cnt_q   <= '0;
            ismst_q <= '0;
            idx_q   <= IDX_RST;
            valid_q <= 1'b0;
            grant_q <= 1'b0;
            coll_q  <= 1'b0;
            disc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            f_ref_q <= bus.i_f_ref;
            cnt_q   <= cnt_d;
            ismst_q <= ismst_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            coll_q  <= coll_d;
            disc_q  <= disc_d;
        end
    end

    // Next-state and next-output decisions for arm / own / release / disconnect.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ismst_d = ismst_q;
        idx_d   = idx_q;
        grant_d = 1'b0;
        coll_d  = 1'b0;
        disc_d  = disc_q;
        case (state_q)
            ARM: begin
                ismst_d = '0;
                disc_d  = 1'b0;
                cnt_d   = '0;
                if (|req) begin
                    state_d = OWN;
                    ismst_d = NUM_CH'(1) << win_idx;
                    idx_d   = win_idx;
                    grant_d = 1'b1;
                    coll_d  = multi_req;
                end
            end
            OWN: begin
                // Other channels going non-idle here is the passthrough echo.
                if (bus.i_violation || stuck_any || !bus.i_mask[idx_q]) begin
                    state_d = DISC;
                    ismst_d = '0;
                    disc_d  = 1'b1;
                    cnt_d   = '0;
                end else if (bus.i_idle[idx_q]) begin
                    state_d = BUF;
                    ismst_d = '0;
                    cnt_d   = '0;
                end
            end
            BUF, DISC: begin
                ismst_d = '0;
                if ((state_q == BUF) && (bus.i_violation || stuck_any)) begin
                    state_d = DISC;
                    disc_d  = 1'b1;
                    cnt_d   = '0;
                end else if (!quiet) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ARM;
                    disc_d  = 1'b0;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ARM;
                ismst_d = '0;
                disc_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
        valid_d = |ismst_d;
    end

    assign bus.o_ismst      = ismst_q;
    assign bus.o_mst_idx    = idx_q;
    assign bus.o_mst_valid  = valid_q;
    assign bus.o_disconnect = disc_q;
    assign bus.o_grant      = grant_q;
    assign bus.o_collision  = coll_q;

endmodule

// File: doc/i2c_passthru_mstr_arb.md
Name: i2c_passthru_mstr_arb

Overview:
N-channel master arbiter for the next-generation I2C/SMBus passthrough hub. It generalises two-channel master detection to NUM_CH buses. It grants bus mastership to the first channel to leave idle, with lowest-index or round-robin tie-break on simultaneous starts. It forces a disconnect on bit violation or stuck bus, and enforces a t_buf quiet period before any new grant. It sits between the per-channel idle/stuck/recover blocks and the bit rx/tx datapath mux.

Parameters:
NUM_CH, 4, number of I2C channels (2..16)
WIDTH_CH, 2, index width = CEILING(LOG2(NUM_CH))
RR_EN, 1, 1 = round-robin tie-break from last grant; 0 = fixed priority, lowest index wins
F_REF_T_BUF, 38, i_f_ref rising edges of all-idle required before re-arming (t_buf)
WIDTH_F_REF_T_BUF, 6, CEILING(LOG2(F_REF_T_BUF+1))

Ports:
i_clk  in  1  system clock
i_rstn  in  1  reset, asynchronous, active-low
i_f_ref  in  1  reference timing signal; rising edges, detected in i_clk domain, are ticks
i_idle  in  NUM_CH  per-channel bus idle from idle/stuck block
i_stuck  in  NUM_CH  per-channel stuck condition (level)
i_mask  in  NUM_CH  1 = channel enabled; 0 = channel ignored for requests and quiet checks
i_violation  in  1  bit rx/tx violation (level, OR of both)
o_ismst  out  NUM_CH  one-hot current master; all zero when none
o_mst_idx  out  WIDTH_CH  index of current master; holds last grant when none
o_mst_valid  out  1  OR of o_ismst
o_disconnect  out  1  datapath must be held in reset and passthrough broken
o_grant  out  1  single-cycle pulse on each new grant
o_collision  out  1  single-cycle pulse when a grant resolved more than one request

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = ARM; o_ismst = 0; o_mst_valid = 0; o_disconnect = 0; o_grant = 0; o_collision = 0.
  - o_mst_idx = NUM_CH-1, which is also last_grant, so the first RR search starts at channel 0.
  - buf counter = 0; f_ref edge register = 0.
- Tick = i_f_ref & ~f_ref_q. One cycle of detection latency.
- req = ~i_idle & i_mask & ~i_stuck. quiet = &(i_idle | ~i_mask) and no unmasked i_stuck.
- All outputs are registered. A decision made in cycle n is visible at cycle n+1.
- States:
  - ARM: req==0 -> stay. Otherwise -> OWN, with the winner selected as follows:
    - one bit set: that channel.
    - >1 bit set: RR_EN=1 takes the first set bit at or after (last_grant+1) mod NUM_CH, wrapping. RR_EN=0 takes the lowest set index. Pulse o_collision.
    - Pulse o_grant; set o_ismst/o_mst_idx; update last_grant.
  - OWN: priority order, highest first:
    - (1) i_violation, or any unmasked i_stuck, or master's i_mask==0 -> DISC, same cycle decision.
    - (2) master's i_idle==1 -> BUF.
    - (3) else stay.
    - Requests from non-master channels are ignored; they are the passthrough echo.
  - BUF: o_ismst = 0, o_disconnect = 0.
    - Counter clears when quiet==0.
    - Counter increments on tick while quiet==1, saturating at F_REF_T_BUF.
    - At count==F_REF_T_BUF and quiet -> ARM, counter cleared.
    - i_violation or unmasked stuck -> DISC.
  - DISC: o_ismst = 0, o_disconnect = 1. Counter rules are the same as BUF. Exit to ARM on expiry; o_disconnect drops the same cycle o_ismst can next rise (one cycle later at earliest).
- An entry into BUF/DISC always clears the counter. A tick coincident with entry is not counted.
- Simultaneous master idle and violation in OWN -> DISC.
- A request arriving during BUF/DISC is not latched. It is re-evaluated in ARM from live req.
- Masking a channel has no effect unless it is the current master, or it becomes relevant to quiet.
- NUM_CH non-power-of-2: the RR wrap uses modulo NUM_CH; indices ≥ NUM_CH are never granted.

Test Plan:
- Single start: NUM_CH=4, ch2 i_idle falls at cycle 10 -> o_ismst=0100, o_mst_idx=2, o_grant pulse at cycle 11; ch2 idle again -> BUF, re-arm after 38 ticks of all-idle.
- RR collision: RR_EN=1, last_grant=1, ch0+ch3 start same cycle -> ch3 granted, o_collision=1. Repeat with last_grant=3 -> ch0 granted.
- Fixed priority: RR_EN=0, ch1+ch2 simultaneous -> ch1 granted every time.
- Violation: OWN ch0, i_violation pulse -> next cycle o_disconnect=1, o_ismst=0. ch3 goes non-idle at tick 20 -> counter clears. ARM only 38 ticks after last non-idle.
- Stuck/mask: OWN ch1; set i_mask[1]=0 -> DISC. Separately, i_stuck[3] while masked -> no effect.
- Async reset asserted mid-OWN (no clock edge) -> all outputs 0 immediately, o_mst_idx=3. After release, first grant uses RR start 0.
